// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch-stage state encoding and IF/ID register layout shared with decode.
package fetch_pkg;
  typedef enum logic [1:0] {FETCH, DROP, HELD} fetch_state_e;
  localparam int IFID_W = 64;
  localparam int INSTR_LSB = 32;
  localparam int PC_LSB = 0;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  function automatic logic [IFID_W-1:0] ifid_pack(input logic [31:0] instr, input logic [31:0] pc);
    ifid_pack = '0;
    ifid_pack[INSTR_LSB +: 32] = instr;
    ifid_pack[PC_LSB +: 32] = pc;
  endfunction
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory req/ack port between fetch (master) and imem (slave).
interface fetch_if;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_ack;
  logic [31:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_hold_buffer.sv
// fetch_hold_buffer: parks one fetched word while decode stalls; load wins over clear.
module fetch_hold_buffer (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic valid
);
  logic [31:0] data_q, data_d;
  logic valid_q, valid_d;
  always_comb begin
    data_d = load ? din : (clear ? '0 : data_q);
    valid_d = load || (valid_q && !clear);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q <= data_d;
      valid_q <= valid_d;
    end
  end
  assign dout = data_q;
  assign valid = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, runs the imem req/ack FSM and fills IFIDReg for decode.
// FETCH_PERF_CNT_EN adds saturating perf_fetched/perf_stalls counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic clk,
  input  logic rst,
  input  logic pcHOLD,
  input  logic BranchControlSignal,
  input  logic [31:0] BranchTarget,
  fetch_if.master imem,
  output logic [IFID_W-1:0] IFIDReg,
  output logic fetch_stall
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls
`endif
);
  localparam logic [IFID_W-1:0] BUBBLE = ifid_pack(NOP_INSTR, 32'h0);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, redir_q, redir_d, pc4, tgt, buf_dout;
  logic [IFID_W-1:0] ifid_q, ifid_d;
  logic req_q, req_d, ack, load_en, buf_load, buf_clear, buf_valid;
  assign pc4 = pc_q + 32'd4;
  assign tgt = BranchTarget & ~32'h3;
  // the cycle right after reset has no request outstanding, so an ack then is ignored
  assign ack = imem.imem_ack && req_q;
  fetch_hold_buffer u_buf (
    .clk(clk), .rst(rst), .load(buf_load), .clear(buf_clear),
    .din(imem.imem_rdata), .dout(buf_dout), .valid(buf_valid)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    redir_d = redir_q;
    ifid_d = ifid_q;
    load_en = 1'b0;
    buf_load = 1'b0;
    buf_clear = 1'b0;
    case (state_q)
      FETCH: begin
        if (BranchControlSignal) begin
          ifid_d = BUBBLE;
          pc_d = ack ? tgt : pc_q;
          redir_d = ack ? redir_q : tgt;
          state_d = ack ? FETCH : DROP;
        end else if (ack && pcHOLD) begin
          buf_load = 1'b1;
          state_d = HELD;
        end else if (ack) begin
          ifid_d = ifid_pack(imem.imem_rdata, pc4);
          pc_d = pc4;
          load_en = 1'b1;
        end else if (!pcHOLD) begin
          ifid_d = BUBBLE;
        end
      end
      DROP: begin
        ifid_d = BUBBLE;
        redir_d = BranchControlSignal ? tgt : redir_q;
        if (ack) begin
          pc_d = BranchControlSignal ? tgt : redir_q;
          state_d = FETCH;
        end
      end
      HELD: begin
        if (BranchControlSignal) begin
          buf_clear = 1'b1;
          pc_d = tgt;
          ifid_d = BUBBLE;
          state_d = FETCH;
        end else if (!pcHOLD && buf_valid) begin
          buf_clear = 1'b1;
          ifid_d = ifid_pack(buf_dout, pc4);
          pc_d = pc4;
          load_en = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    req_d = state_d != HELD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      redir_q <= '0;
      ifid_q <= BUBBLE;
      req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      redir_q <= redir_d;
      ifid_q <= ifid_d;
      req_q <= req_d;
    end
  end
  assign imem.imem_req = req_q;
  assign imem.imem_addr = pc_q;
  assign IFIDReg = ifid_q;
  assign fetch_stall = rst || !load_en;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d, stalls_q, stalls_d;
  always_comb begin
    fetched_d = fetched_q + {31'b0, load_en && !(&fetched_q)};
    stalls_d = stalls_q + {31'b0, fetch_stall && !(&stalls_q)};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      stalls_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      stalls_q <= stalls_d;
    end
  end
  assign perf_fetched = fetched_q;
  assign perf_stalls = stalls_q;
`endif
endmodule
